// File: rtl/mitll_merget_sync.sv
// Clock-sampled RSFQ merger: two toggle-encoded pulse inputs joined into one delayed
// toggle output, with a critical-timing window check. Optional macro: MERGET_ERRCOUNT_EN.
module mitll_merget_sync #(
    parameter int DELAY_CYC = 5,
    parameter int CT_CYC    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in1,
    input  logic       in2,
    input  logic       err_clr,
    output logic       out,
    output logic       err,
    output logic [7:0] err_count
);

    localparam int CTW     = (CT_CYC > 1) ? $clog2(CT_CYC) : 1;
    localparam int CT_LOAD = (CT_CYC > 1) ? (CT_CYC - 1) : 0;

    logic                 in1_q_reg;
    logic                 in2_q_reg;
    logic [CTW-1:0]       ct_reg;
    logic [CTW-1:0]       ct_next;
    logic [DELAY_CYC-1:0] dl_reg;
    logic [DELAY_CYC-1:0] dl_next;
    logic                 out_reg;
    logic                 err_reg;
    logic                 cand;
    logic                 window_open;
    logic                 accepted;
    logic                 violation;

    assign cand        = (in1 != in1_q_reg) | (in2 != in2_q_reg);
    assign window_open = (ct_reg != '0);
    assign accepted    = cand & ~window_open;
    assign violation   = cand & window_open;

    // A violation leaves the window running down; only an accepted pulse reloads it.
    always_comb begin
        ct_next = ct_reg;
        if (accepted) begin
            ct_next = CTW'(CT_LOAD);
        end else if (window_open) begin
            ct_next = ct_reg - 1'b1;
        end
    end

    assign dl_next[0] = accepted;
    generate
        for (genvar gi = 1; gi < DELAY_CYC; gi++) begin : g_delay
            assign dl_next[gi] = dl_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in1_q_reg <= in1;
            in2_q_reg <= in2;
            ct_reg    <= '0;
            dl_reg    <= '0;
            out_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            in1_q_reg <= in1;
            in2_q_reg <= in2;
            ct_reg    <= ct_next;
            dl_reg    <= dl_next;
            out_reg   <= out_reg ^ dl_reg[DELAY_CYC-1];
            if (violation) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign out = out_reg;
    assign err = err_reg;

`ifdef MERGET_ERRCOUNT_EN
    logic [7:0] cnt_reg;

    // A violation on the clearing edge counts as the first event after the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= 8'd0;
        end else if (violation && err_clr) begin
            cnt_reg <= 8'd1;
        end else if (violation) begin
            if (cnt_reg != 8'hFF) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end else if (err_clr) begin
            cnt_reg <= 8'd0;
        end
    end

    assign err_count = cnt_reg;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_mitll_merget_sync.sv
// Directed bench for mitll_merget_sync: expected output toggle edges are queued when
// pulses are driven and retired as the edge count reaches them.
module tb_mitll_merget_sync;

`ifdef MERGET_ERRCOUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in1 = 1'b0;
    logic       in2 = 1'b0;
    logic       err_clr = 1'b0;
    logic       out;
    logic       err;
    logic [7:0] err_count;

    int total = 0;
    int bad = 0;
    int edge_no = 0;
    int exp_cnt = 0;
    logic exp_out = 1'b0;
    logic exp_err = 1'b0;
    int toggle_q[$];

    mitll_merget_sync #(.DELAY_CYC(5), .CT_CYC(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in1(in1),
        .in2(in2),
        .err_clr(err_clr),
        .out(out),
        .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_no, obs, exp_v);
        end
    endtask

    // Advance one edge, retire due toggles, compare all outputs just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_no++;
        if (toggle_q.size() > 0 && toggle_q[0] == edge_no) begin
            void'(toggle_q.pop_front());
            exp_out = ~exp_out;
        end
        check("out", {31'd0, out}, {31'd0, exp_out});
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("err_count", {24'd0, err_count}, exp_cnt);
    endtask

    task automatic run_to(input int e);
        while (edge_no < e) tick();
    endtask

    task automatic do_reset(input logic a, input logic b);
        in1 = a;
        in2 = b;
        rst_n = 1'b0;
        toggle_q.delete();
        exp_out = 1'b0;
        exp_err = 1'b0;
        exp_cnt = 0;
        edge_no = -1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic note_violation();
        exp_err = 1'b1;
        if (CNT_EN && exp_cnt < 255) exp_cnt++;
    endtask

    initial begin
        // Post-reset input level must not look like a pulse.
        do_reset(1'b1, 1'b0);
        run_to(20);
        $display("txn hold_after_reset: out=%0d err=%0d", out, err);

        // Single pulse on in1 at edge 10 -> toggle at 15.
        do_reset(1'b0, 1'b0);
        run_to(9);
        in1 = ~in1;
        toggle_q.push_back(15);
        run_to(25);
        check("single_drain", toggle_q.size(), 0);
        $display("txn single_pulse: out=%0d err=%0d", out, err);

        // Simultaneous pulses merge into one toggle.
        do_reset(1'b0, 1'b0);
        run_to(9);
        in1 = ~in1;
        in2 = ~in2;
        toggle_q.push_back(15);
        run_to(25);
        check("merge_drain", toggle_q.size(), 0);
        $display("txn same_edge_merge: out=%0d err=%0d", out, err);

        // in2 inside the window is dropped; in2 at edge 15 is accepted.
        do_reset(1'b0, 1'b0);
        run_to(9);
        in1 = ~in1;
        toggle_q.push_back(15);
        run_to(11);
        in2 = ~in2;
        note_violation();
        tick();
        run_to(14);
        in2 = ~in2;
        toggle_q.push_back(20);
        run_to(25);
        check("window_drain", toggle_q.size(), 0);
        $display("txn window_violation: out=%0d err=%0d err_count=%0d", out, err, err_count);

        // 300 violations: toggling every edge gives one accept per 5 edges.
        do_reset(1'b0, 1'b0);
        begin
            int viol = 0;
            while (viol < 300) begin
                in1 = ~in1;
                if ((edge_no % 5) == 0) begin
                    toggle_q.push_back(edge_no + 1 + 5);
                end else begin
                    note_violation();
                    viol++;
                end
                tick();
            end
        end
        run_to(edge_no + 10);
        check("sat_count", {24'd0, err_count}, CNT_EN ? 255 : 0);
        check("sat_drain", toggle_q.size(), 0);
        $display("txn saturate: err=%0d err_count=%0d", err, err_count);
        err_clr = 1'b1;
        exp_err = 1'b0;
        exp_cnt = 0;
        tick();
        err_clr = 1'b0;
        $display("txn err_clr: err=%0d err_count=%0d", err, err_count);

        // Violation on the clearing edge wins.
        in1 = ~in1;
        toggle_q.push_back(edge_no + 1 + 5);
        tick();
        in1 = ~in1;
        err_clr = 1'b1;
        exp_err = 1'b1;
        exp_cnt = CNT_EN ? 1 : 0;
        tick();
        err_clr = 1'b0;
        run_to(edge_no + 10);
        $display("txn clr_vs_violation: err=%0d err_count=%0d", err, err_count);

        // Reset mid-flight discards the pending toggle.
        do_reset(1'b0, 1'b0);
        run_to(9);
        in1 = ~in1;
        toggle_q.push_back(15);
        run_to(11);
        rst_n = 1'b0;
        toggle_q.delete();
        exp_out = 1'b0;
        tick();
        rst_n = 1'b1;
        run_to(20);
        check("midflight_out", {31'd0, out}, 32'd0);
        $display("txn reset_midflight: out=%0d", out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
